pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the RV32I core.
- Generates the stall, flush and PC-select controls for fetch (S1), the stage-2/3 pipeline register (S2) and the execute/memory stage (S3).
- Sequences boot, load-use interlock, branch redirect, data-memory wait states with timeout, and trap entry.
- Sits beside the datapath; its flush_s2_out forces a bubble (all write enables 0, wb select = WB_ALU) into the stage-2/3 register.

Parameters:
BOOT_CYCLES, 2, cycles after reset release during which fetch is held and flushed (>=1).
MEM_TIMEOUT, 255, max MEM_WAIT cycles before a bus error (>=2, < 2^TIMEOUT_W).
TIMEOUT_W, 8, width of the wait/boot counter.

Ports:
clk_in  input  1  clock, rising edge
reset_in  input  1  asynchronous reset, active-high
trap_taken_in  input  1  exception/interrupt accepted this cycle
branch_taken_in  input  1  branch/jump resolved taken in S2
dmem_req_in  input  1  S3 issues a load/store
dmem_ack_in  input  1  data memory completes the access
load_s3_in  input  1  S3 instruction is a load
rd_addr_s3_in  input  5  S3 destination register
rs1_addr_s2_in  input  5  S2 source 1
rs2_addr_s2_in  input  5  S2 source 2
rs1_used_in  input  1  S2 reads rs1
rs2_used_in  input  1  S2 reads rs2
stall_s1_out  output  1  hold PC and S1 register
stall_s2_out  output  1  hold stage-2/3 register
stall_s3_out  output  1  hold S3/writeback register
flush_s1_out  output  1  kill the fetched instruction
flush_s2_out  output  1  load a bubble into the stage-2/3 register
pc_sel_out  output  2  00 PC+4, 01 branch target, 10 trap vector, 11 BOOT_ADDRESS
bus_err_out  output  1  one-cycle pulse on memory timeout
state_out  output  2  00 BOOT, 01 RUN, 10 MEM_WAIT, 11 TRAP
stall_cnt_out  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_in; reset_in is asynchronous and active-high.
- State register and a TIMEOUT_W-bit counter.
- Outputs are combinational from the state, the counter and the inputs.
- Reset: state = BOOT, counter = 0, bus_err_out = 0, stall_cnt_out = 0.
- Outputs while reset is held: stall_s1 = 1, flush_s1 = 1, flush_s2 = 1, stall_s2 = stall_s3 = 0, pc_sel = 11.
- Reset asserted in any state, including mid-MEM_WAIT, aborts immediately to BOOT.
- BOOT:
  - Outputs as during reset; the counter increments each cycle.
  - At count == BOOT_CYCLES-1: clear the counter and go to RUN.
- RUN: defaults are all stalls/flushes 0 and pc_sel 00. Priority is trap > mem wait > branch > load-use.
  - trap_taken_in: pc_sel = 10, flush_s1 = flush_s2 = 1; next state TRAP.
  - dmem_req_in & !dmem_ack_in: stall_s1 = stall_s2 = stall_s3 = 1; counter cleared; next state MEM_WAIT.
  - dmem_req_in & dmem_ack_in in the same cycle: no stall.
  - branch_taken_in: pc_sel = 01, flush_s1 = 1.
  - Load-use hazard (load_s3_in, rd_addr_s3_in != 0, and rd equals rs1 with rs1_used_in, or rd equals rs2 with rs2_used_in): stall_s1 = 1, flush_s2 = 1 for exactly that cycle.
  - A branch and a load-use hazard in the same cycle: branch wins and the hazard is not applied.
- MEM_WAIT:
  - Ignores branch, trap and hazard inputs. Upstream holds them stable while stalled; a held trap is taken in RUN on the following cycle.
  - dmem_ack_in: all stalls 0 this cycle; next state RUN.
  - No ack: stall_s1..s3 = 1, counter increments.
  - No ack at count == MEM_TIMEOUT-1: bus_err_out = 1, pc_sel = 10, flush_s1 = flush_s2 = 1, stalls 0; next state TRAP.
  - Ack and timeout in the same cycle: ack wins, no error.
- TRAP: flush_s1 = flush_s2 = 1, pc_sel 00, stalls 0; unconditionally RUN next cycle.
- Counter wrap: unreachable, given the parameter limits.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: stall_cnt_out increments on every cycle with stall_s1_out = 1 outside BOOT. It saturates at 0xFFFFFFFF and clears only on reset.
- Undefined: stall_cnt_out is tied to 0 and no counter logic is generated.

Test Plan:
- Reset held 3 cycles then released, BOOT_CYCLES = 2 -> pc_sel = 11 and flush_s1 = 1 for 2 cycles after release; state_out = 01 on the 3rd cycle.
- load_s3 = 1, rd_s3 = 5, rs1_s2 = 5, rs1_used = 1 -> stall_s1 = 1 and flush_s2 = 1 for one cycle. Same stimulus with rd_s3 = 0 -> no stall.
- dmem_req = 1 and dmem_ack after 4 cycles -> stall_s1..s3 = 1 for 4 cycles, 0 on the ack cycle, state back to RUN; with STALL_PERF_CNT_EN, stall_cnt_out = 4.
- dmem_req, never acked, MEM_TIMEOUT = 8 -> bus_err_out pulses on the 8th MEM_WAIT cycle with pc_sel = 10, then TRAP, then RUN.
- branch_taken and load-use hazard in the same cycle -> pc_sel = 01, flush_s1 = 1, stall_s1 = 0; trap_taken together with branch_taken -> pc_sel = 10.
- reset_in asserted asynchronously mid-MEM_WAIT -> state_out = 00 and pc_sel = 11 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: boot hold, load-use interlock, branch redirect, dmem wait/timeout and trap entry.
// Define STALL_PERF_CNT_EN to build the saturating stall-cycle performance counter on stall_cnt_out.
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        trap_taken_in,
    input  logic        branch_taken_in,
    input  logic        dmem_req_in,
    input  logic        dmem_ack_in,
    input  logic        load_s3_in,
    input  logic [4:0]  rd_addr_s3_in,
    input  logic [4:0]  rs1_addr_s2_in,
    input  logic [4:0]  rs2_addr_s2_in,
    input  logic        rs1_used_in,
    input  logic        rs2_used_in,
    output logic        stall_s1_out,
    output logic        stall_s2_out,
    output logic        stall_s3_out,
    output logic        flush_s1_out,
    output logic        flush_s2_out,
    output logic [1:0]  pc_sel_out,
    output logic        bus_err_out,
    output logic [1:0]  state_out,
    output logic [31:0] stall_cnt_out
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_TRAP     = 2'b11
    } state_e;

    localparam logic [TIMEOUT_W-1:0] BOOT_LAST    = TIMEOUT_W'(BOOT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 memMiss;
    logic                 loadUse;
    logic                 bootDone;
    logic                 timedOut;

    assign memMiss  = dmem_req_in & ~dmem_ack_in;
    assign loadUse  = load_s3_in && (rd_addr_s3_in != 5'd0) &&
                      ((rs1_used_in && (rd_addr_s3_in == rs1_addr_s2_in)) ||
                       (rs2_used_in && (rd_addr_s3_in == rs2_addr_s2_in)));
    assign bootDone = (cnt_q == BOOT_LAST);
    assign timedOut = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The shared counter times the boot hold and the memory wait; it restarts on every state entry that uses it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                if (bootDone) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_RUN: begin
                if (trap_taken_in) begin
                    state_d = ST_TRAP;
                end else if (memMiss) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_in) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (timedOut) begin
                    state_d = ST_TRAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A branch suppresses the load-use bubble: the younger instruction is being flushed anyway.
    always_comb begin
        stall_s1_out = 1'b0;
        stall_s2_out = 1'b0;
        stall_s3_out = 1'b0;
        flush_s1_out = 1'b0;
        flush_s2_out = 1'b0;
        pc_sel_out   = 2'b00;
        bus_err_out  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                stall_s1_out = 1'b1;
                flush_s1_out = 1'b1;
                flush_s2_out = 1'b1;
                pc_sel_out   = 2'b11;
            end
            ST_RUN: begin
                if (trap_taken_in) begin
                    pc_sel_out   = 2'b10;
                    flush_s1_out = 1'b1;
                    flush_s2_out = 1'b1;
                end else if (memMiss) begin
                    stall_s1_out = 1'b1;
                    stall_s2_out = 1'b1;
                    stall_s3_out = 1'b1;
                end else if (branch_taken_in) begin
                    pc_sel_out   = 2'b01;
                    flush_s1_out = 1'b1;
                end else if (loadUse) begin
                    stall_s1_out = 1'b1;
                    flush_s2_out = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ack_in) begin
                    if (timedOut) begin
                        bus_err_out  = 1'b1;
                        pc_sel_out   = 2'b10;
                        flush_s1_out = 1'b1;
                        flush_s2_out = 1'b1;
                    end else begin
                        stall_s1_out = 1'b1;
                        stall_s2_out = 1'b1;
                        stall_s3_out = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                flush_s1_out = 1'b1;
                flush_s2_out = 1'b1;
            end
        endcase
    end

    assign state_out = state_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stallCnt_q <= '0;
        end else if ((state_q != ST_BOOT) && stall_s1_out && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt_out = stallCnt_q;
`else
    assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 8;
    localparam int TIMEOUT_W   = 8;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_TRAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap = 1'b0, branch = 1'b0, req = 1'b0, ack = 1'b0, load = 1'b0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic        u1 = 1'b0, u2 = 1'b0;

    logic        s1, s2, s3, f1, f2, busErr;
    logic [1:0]  pc, state;
    logic [31:0] stallCnt;

    int checkCount = 0;
    int errorCount = 0;

    int          mMode = M_BOOT;
    int          mBootCnt = 0;
    int          mWaitCnt = 0;
    logic [31:0] mStallCnt = 32'd0;

    typedef struct packed {
        logic       s1, s2, s3, f1, f2;
        logic [1:0] pc;
        logic       busErr;
    } exp_t;

    pipe_hazard_ctrl #(
        .BOOT_CYCLES(BOOT_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .trap_taken_in  (trap),
        .branch_taken_in(branch),
        .dmem_req_in    (req),
        .dmem_ack_in    (ack),
        .load_s3_in     (load),
        .rd_addr_s3_in  (rd),
        .rs1_addr_s2_in (rs1),
        .rs2_addr_s2_in (rs2),
        .rs1_used_in    (u1),
        .rs2_used_in    (u2),
        .stall_s1_out   (s1),
        .stall_s2_out   (s2),
        .stall_s3_out   (s3),
        .flush_s1_out   (f1),
        .flush_s2_out   (f2),
        .pc_sel_out     (pc),
        .bus_err_out    (busErr),
        .state_out      (state),
        .stall_cnt_out  (stallCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic b, input logic rq, input logic ak,
                                 input logic ld, input logic [4:0] rdv, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic uu1, input logic uu2);
        @(posedge clk);
        #1;
        trap = t; branch = b; req = rq; ack = ak; load = ld;
        rd = rdv; rs1 = r1; rs2 = r2; u1 = uu1; u2 = uu2;
    endtask

    // Outputs implied by the mode the model is in and the inputs currently presented.
    function automatic exp_t modelOutputs();
        exp_t e;
        logic hazard;
        e = '0;
        hazard = load && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        if (mMode == M_BOOT) begin
            e.s1 = 1; e.f1 = 1; e.f2 = 1; e.pc = 2'b11;
        end else if (mMode == M_RUN) begin
            if (trap) begin
                e.pc = 2'b10; e.f1 = 1; e.f2 = 1;
            end else if (req && !ack) begin
                e.s1 = 1; e.s2 = 1; e.s3 = 1;
            end else if (branch) begin
                e.pc = 2'b01; e.f1 = 1;
            end else if (hazard) begin
                e.s1 = 1; e.f2 = 1;
            end
        end else if (mMode == M_WAIT) begin
            if (!ack && mWaitCnt == MEM_TIMEOUT - 1) begin
                e.busErr = 1; e.pc = 2'b10; e.f1 = 1; e.f2 = 1;
            end else if (!ack) begin
                e.s1 = 1; e.s2 = 1; e.s3 = 1;
            end
        end else begin
            e.f1 = 1; e.f2 = 1;
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            mMode = M_BOOT; mBootCnt = 0; mWaitCnt = 0; mStallCnt = 32'd0;
        end else begin
            e = modelOutputs();
            if (mMode != M_BOOT && e.s1 && mStallCnt != 32'hFFFF_FFFF) mStallCnt++;
            if (mMode == M_BOOT) begin
                mBootCnt++;
                if (mBootCnt == BOOT_CYCLES) mMode = M_RUN;
            end else if (mMode == M_RUN) begin
                if (trap) mMode = M_TRAP;
                else if (req && !ack) begin
                    mMode = M_WAIT; mWaitCnt = 0;
                end
            end else if (mMode == M_WAIT) begin
                if (ack) mMode = M_RUN;
                else if (mWaitCnt == MEM_TIMEOUT - 1) mMode = M_TRAP;
                else mWaitCnt++;
            end else begin
                mMode = M_RUN;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = modelOutputs();
        checkOutput("m_stall_s1", 32'(s1), 32'(e.s1));
        checkOutput("m_stall_s2", 32'(s2), 32'(e.s2));
        checkOutput("m_stall_s3", 32'(s3), 32'(e.s3));
        checkOutput("m_flush_s1", 32'(f1), 32'(e.f1));
        checkOutput("m_flush_s2", 32'(f2), 32'(e.f2));
        checkOutput("m_pc_sel", 32'(pc), 32'(e.pc));
        checkOutput("m_bus_err", 32'(busErr), 32'(e.busErr));
        checkOutput("m_state", 32'(state), 32'(mMode));
`ifdef STALL_PERF_CNT_EN
        checkOutput("m_stall_cnt", stallCnt, mStallCnt);
`else
        checkOutput("m_stall_cnt", stallCnt, 32'd0);
`endif
    end

    initial begin
        logic stubborn;
        stubborn = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pc_sel", 32'(pc), 32'd3);
        checkOutput("rst_stall_s1", 32'(s1), 32'd1);
        checkOutput("rst_flush_s2", 32'(f2), 32'd1);
        checkOutput("rst_stall_s2", 32'(s2), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < BOOT_CYCLES; i++) begin
            @(negedge clk);
            checkOutput("boot_pc_sel", 32'(pc), 32'd3);
            checkOutput("boot_flush_s1", 32'(f1), 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("boot_to_run", 32'(state), 32'd1);

        // Access acknowledged on the fifth cycle: four stalled cycles, then release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("mw_stall_s1", 32'(s1), 32'd1);
            checkOutput("mw_stall_s3", 32'(s3), 32'd1);
        end
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("mw_ack_stall", 32'(s1), 32'd0);
        checkOutput("mw_ack_state", 32'(state), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("mw_back_run", 32'(state), 32'd1);
`ifdef STALL_PERF_CNT_EN
        checkOutput("mw_stall_cnt", stallCnt, 32'd4);
`else
        checkOutput("mw_stall_cnt", stallCnt, 32'd0);
`endif

        applyStimulus(0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        @(negedge clk);
        checkOutput("lu_stall_s1", 32'(s1), 32'd1);
        checkOutput("lu_flush_s2", 32'(f2), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("lu_x0_stall", 32'(s1), 32'd0);
        checkOutput("lu_x0_flush", 32'(f2), 32'd0);

        applyStimulus(0, 1, 0, 0, 1, 5, 5, 0, 1, 0);
        @(negedge clk);
        checkOutput("br_lu_pc_sel", 32'(pc), 32'd1);
        checkOutput("br_lu_flush_s1", 32'(f1), 32'd1);
        checkOutput("br_lu_stall_s1", 32'(s1), 32'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("trap_br_pc_sel", 32'(pc), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("trap_state", 32'(state), 32'd3);
        checkOutput("trap_pc_sel", 32'(pc), 32'd0);
        @(negedge clk);
        checkOutput("trap_to_run", 32'(state), 32'd1);

        // Never acknowledged: error pulse lands on the eighth waiting cycle.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("to_bus_err", 32'(busErr), (i == MEM_TIMEOUT - 1) ? 32'd1 : 32'd0);
            checkOutput("to_pc_sel", 32'(pc), (i == MEM_TIMEOUT - 1) ? 32'd2 : 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("to_trap", 32'(state), 32'd3);
        checkOutput("to_err_pulse", 32'(busErr), 32'd0);
        @(negedge clk);
        checkOutput("to_run", 32'(state), 32'd1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ar_in_wait", 32'(state), 32'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_state", 32'(state), 32'd0);
        checkOutput("ar_pc_sel", 32'(pc), 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) stubborn = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 199) == 0);
            trap   = ($urandom_range(0, 15) == 0);
            branch = ($urandom_range(0, 4) == 0);
            req    = ($urandom_range(0, 2) == 0);
            ack    = stubborn ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
            load   = 1'($urandom_range(0, 1));
            rd     = 5'($urandom_range(0, 3));
            rs1    = 5'($urandom_range(0, 3));
            rs2    = 5'($urandom_range(0, 3));
            u1     = 1'($urandom_range(0, 1));
            u2     = 1'($urandom_range(0, 1));
            if (!rst && $urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
            end
        end

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
